// File: rtl/alu_frame_if.sv
// Bus between the frame controller and its surroundings: UART receive and
// transmit strobes, the combinational ALU operands/result, and status.
//
// Handshake semantics: i_rx_done is a one-cycle strobe qualifying i_rx_data;
// o_tx_start is a one-cycle request and o_tx_data stays stable until the
// matching one-cycle i_tx_done; i_tx_done is honoured only while a byte is
// outstanding, and i_rx_done only while a frame is being received.
interface alu_frame_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 6
);
  logic              i_rx_done;
  logic [7:0]        i_rx_data;
  logic [DATA_W-1:0] i_alu_result;
  logic              i_tx_done;
  logic [DATA_W-1:0] o_alu_a;
  logic [DATA_W-1:0] o_alu_b;
  logic [OP_W-1:0]   o_alu_op;
  logic [7:0]        o_tx_data;
  logic              o_tx_start;
  logic              o_busy;
  logic              o_err;

  // Controller side
  modport slave (
    input  i_rx_done, i_rx_data, i_alu_result, i_tx_done,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_err
  );

  // Environment side (UART + ALU)
  modport master (
    output i_rx_done, i_rx_data, i_alu_result, i_tx_done,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_err
  );
endinterface

// File: rtl/alu_frame_ctrl.sv
// Command-frame controller: receives opcode, operand A, operand B (MSB first)
// and an XOR checksum byte, runs the external ALU, then returns the result
// MSB first through the UART with a start/done handshake. Inter-byte timeout
// and checksum errors produce a one-cycle o_err pulse. All outputs registered.
module alu_frame_ctrl #(
  parameter int DATA_W      = 16,
  parameter int OP_W        = 6,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic             clk,
  input  logic             reset,
  alu_frame_if.slave       io_bus,
  output logic [2:0]       o_dbg_state
);
  localparam int NB   = DATA_W / 8;
  localparam int BC_W = $clog2(NB + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NB - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RX_A, S_RX_B, S_RX_CHK, S_EXEC, S_TX_SEND, S_TX_WAIT
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_a, w_a_nxt;
  logic [DATA_W-1:0] r_b, w_b_nxt;
  logic [OP_W-1:0]   r_op, w_op_nxt;
  logic [DATA_W-1:0] r_res, w_res_nxt;
  logic [7:0]        r_chk, w_chk_nxt;
  logic [BC_W-1:0]   r_bcnt, w_bcnt_nxt;
  logic [TO_W-1:0]   r_tmo, w_tmo_nxt;
  logic [7:0]        r_tx_data, w_tx_data_nxt;
  logic              r_tx_start, w_tx_start_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_err, w_err_nxt;
  logic              w_in_rx;

  // Next-state and next-output logic; pulses default low, registers hold
  always_comb begin
    w_state_nxt    = r_state;
    w_a_nxt        = r_a;
    w_b_nxt        = r_b;
    w_op_nxt       = r_op;
    w_res_nxt      = r_res;
    w_chk_nxt      = r_chk;
    w_bcnt_nxt     = r_bcnt;
    w_tmo_nxt      = '0;
    w_tx_data_nxt  = r_tx_data;
    w_tx_start_nxt = 1'b0;
    w_err_nxt      = 1'b0;
    w_in_rx        = (r_state == S_RX_A) || (r_state == S_RX_B) || (r_state == S_RX_CHK);

    case (r_state)
      S_IDLE: begin
        if (io_bus.i_rx_done) begin
          w_op_nxt    = io_bus.i_rx_data[OP_W-1:0];
          w_chk_nxt   = io_bus.i_rx_data;
          w_bcnt_nxt  = '0;
          w_state_nxt = S_RX_A;
        end
      end
      S_RX_A: begin
        if (io_bus.i_rx_done) begin
          w_a_nxt   = (r_a << 8) | DATA_W'(io_bus.i_rx_data);
          w_chk_nxt = r_chk ^ io_bus.i_rx_data;
          if (r_bcnt == LAST_BYTE) begin
            w_bcnt_nxt  = '0;
            w_state_nxt = S_RX_B;
          end else begin
            w_bcnt_nxt = r_bcnt + 1'b1;
          end
        end
      end
      S_RX_B: begin
        if (io_bus.i_rx_done) begin
          w_b_nxt   = (r_b << 8) | DATA_W'(io_bus.i_rx_data);
          w_chk_nxt = r_chk ^ io_bus.i_rx_data;
          if (r_bcnt == LAST_BYTE) begin
            w_bcnt_nxt  = '0;
            w_state_nxt = S_RX_CHK;
          end else begin
            w_bcnt_nxt = r_bcnt + 1'b1;
          end
        end
      end
      S_RX_CHK: begin
        if (io_bus.i_rx_done) begin
          if (io_bus.i_rx_data == r_chk) begin
            w_state_nxt = S_EXEC;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_EXEC: begin
        w_res_nxt   = io_bus.i_alu_result;
        w_bcnt_nxt  = '0;
        w_state_nxt = S_TX_SEND;
      end
      S_TX_SEND: begin
        w_tx_data_nxt  = r_res[DATA_W-1 -: 8];
        w_tx_start_nxt = 1'b1;
        w_state_nxt    = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (io_bus.i_tx_done) begin
          w_res_nxt = r_res << 8;
          if (r_bcnt == LAST_BYTE) begin
            w_bcnt_nxt  = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_bcnt_nxt  = r_bcnt + 1'b1;
            w_state_nxt = S_TX_SEND;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Inter-byte timeout: counts silent cycles while a frame is open
    if (w_in_rx && !io_bus.i_rx_done) begin
      if (r_tmo == TO_LAST) begin
        w_err_nxt   = 1'b1;
        w_bcnt_nxt  = '0;
        w_state_nxt = S_IDLE;
      end else begin
        w_tmo_nxt = r_tmo + 1'b1;
      end
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_res      <= '0;
      r_chk      <= '0;
      r_bcnt     <= '0;
      r_tmo      <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_op       <= w_op_nxt;
      r_res      <= w_res_nxt;
      r_chk      <= w_chk_nxt;
      r_bcnt     <= w_bcnt_nxt;
      r_tmo      <= w_tmo_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_busy     <= w_busy_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign io_bus.o_alu_a    = r_a;
  assign io_bus.o_alu_b    = r_b;
  assign io_bus.o_alu_op   = r_op;
  assign io_bus.o_tx_data  = r_tx_data;
  assign io_bus.o_tx_start = r_tx_start;
  assign io_bus.o_busy     = r_busy;
  assign io_bus.o_err      = r_err;
  assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Bench for alu_frame_ctrl: directed frames from the test plan plus random
// frames, checked against a frame-level model of the expected reply bytes.
module tb_alu_frame_ctrl;
  localparam int DATA_W      = 16;
  localparam int OP_W        = 6;
  localparam int TIMEOUT_CYC = 50;
  localparam int NB          = DATA_W / 8;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_frame_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();
  logic [2:0] dbg_state;

  alu_frame_ctrl #(.DATA_W(DATA_W), .OP_W(OP_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .io_bus      (bus),
    .o_dbg_state (dbg_state)
  );

  // External ALU: opcode low two bits select ADD / SUB / XOR / AND
  function automatic logic [DATA_W-1:0] alu_ref(input logic [OP_W-1:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    case (op[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return a & b;
    endcase
  endfunction
  assign bus.i_alu_result = alu_ref(bus.o_alu_op, bus.o_alu_a, bus.o_alu_b);

  // Scoreboard state
  logic [7:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;
  int start_cnt = 0;

  always @(negedge clk) begin
    if (bus.o_err === 1'b1) err_cnt++;
    if (bus.o_tx_start === 1'b1) start_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver tasks (all called and returning on a falling edge)
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_done = 1'b1;
    bus.i_rx_data = b;
    tick();
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = 8'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_a"},     bus.o_alu_a, '0);
    check_eq({tag, "_b"},     bus.o_alu_b, '0);
    check_eq({tag, "_op"},    bus.o_alu_op, '0);
    check_eq({tag, "_txd"},   bus.o_tx_data, '0);
    check_eq({tag, "_start"}, bus.o_tx_start, 1'b0);
    check_eq({tag, "_busy"},  bus.o_busy, 1'b0);
    check_eq({tag, "_err"},   bus.o_err, 1'b0);
    check_eq({tag, "_state"}, dbg_state, 3'd0);
  endtask

  // One full frame; bad: corrupt checksum, inject: stray rx bytes during
  // EXEC/TX_WAIT, rst_mid: reset pulse between the first and second tx byte
  task automatic run_frame(input logic [7:0] op, input logic [DATA_W-1:0] a,
                           input logic [DATA_W-1:0] b, input bit bad,
                           input bit inject, input bit rst_mid);
    logic [7:0] fr[$];
    logic [7:0] x;
    logic [DATA_W-1:0] t;
    logic [DATA_W-1:0] res;
    logic [7:0] held;
    int e0, s0, d;
    fr.push_back(op);
    for (int i = 0; i < NB; i++) begin t = a >> (8 * (NB - 1 - i)); fr.push_back(t[7:0]); end
    for (int i = 0; i < NB; i++) begin t = b >> (8 * (NB - 1 - i)); fr.push_back(t[7:0]); end
    x = 8'h00;
    foreach (fr[i]) x = x ^ fr[i];
    if (bad) x = x ^ 8'($urandom_range(1, 255));
    res = alu_ref(op[OP_W-1:0], a, b);
    exp_q.delete();
    for (int i = 0; i < NB; i++) begin t = res >> (8 * (NB - 1 - i)); exp_q.push_back(t[7:0]); end
    e0 = err_cnt;
    s0 = start_cnt;

    foreach (fr[i]) begin
      send_byte(fr[i]);
      repeat ($urandom_range(0, 3)) tick();
    end
    check_eq("alu_a", bus.o_alu_a, a);
    check_eq("alu_b", bus.o_alu_b, b);
    check_eq("alu_op", bus.o_alu_op, op[OP_W-1:0]);
    send_byte(x);

    if (bad) begin
      check_eq("chk_err_pulse", bus.o_err, 1'b1);
      check_eq("chk_err_busy", bus.o_busy, 1'b0);
      tick();
      check_eq("chk_err_width", bus.o_err, 1'b0);
      check_eq("chk_err_state", dbg_state, 3'd0);
      repeat (4) tick();
      check_eq("chk_err_no_start", start_cnt - s0, 0);
      check_eq("chk_err_count", err_cnt - e0, 1);
      check_eq("chk_err_keep_a", bus.o_alu_a, a);
      check_eq("chk_err_keep_b", bus.o_alu_b, b);
      return;
    end

    check_eq("exec_no_err", bus.o_err, 1'b0);
    check_eq("exec_no_start", bus.o_tx_start, 1'b0);
    if (inject) send_byte(8'hFF); else tick();
    check_eq("send_no_start", bus.o_tx_start, 1'b0);
    tick();
    for (int i = 0; i < NB; i++) begin
      check_eq("tx_start_lat", bus.o_tx_start, 1'b1);
      check_eq("tx_byte", bus.o_tx_data, exp_q.pop_front());
      held = bus.o_tx_data;
      d = $urandom_range(1, 4);
      for (int k = 0; k < d; k++) begin
        if (inject && k == 0) send_byte(8'hFF); else tick();
        check_eq("tx_hold", bus.o_tx_data, held);
        check_eq("tx_single_start", bus.o_tx_start, 1'b0);
      end
      bus.i_tx_done = 1'b1;
      tick();
      bus.i_tx_done = 1'b0;
      if (rst_mid) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_all_zero("mid_rst");
        repeat (6) tick();
        check_eq("mid_rst_no_start", start_cnt - s0, 1);
        return;
      end
      if (i == NB - 1) begin
        check_eq("busy_after_last", bus.o_busy, 1'b0);
      end else begin
        check_eq("tx_gap_start", bus.o_tx_start, 1'b0);
        check_eq("tx_gap_busy", bus.o_busy, 1'b1);
        tick();
      end
    end
    repeat (3) tick();
    check_eq("tx_start_count", start_cnt - s0, NB);
    check_eq("frame_no_err", err_cnt - e0, 0);
    check_eq("frame_end_state", dbg_state, 3'd0);
  endtask

  task automatic run_timeout();
    int s0;
    s0 = start_cnt;
    send_byte(8'h20);
    send_byte(8'h12);
    repeat (TIMEOUT_CYC - 1) tick();
    check_eq("tmo_early", bus.o_err, 1'b0);
    check_eq("tmo_busy_before", bus.o_busy, 1'b1);
    tick();
    check_eq("tmo_pulse", bus.o_err, 1'b1);
    check_eq("tmo_busy", bus.o_busy, 1'b0);
    tick();
    check_eq("tmo_width", bus.o_err, 1'b0);
    check_eq("tmo_no_start", start_cnt - s0, 0);
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Main sequence and final report
  initial begin
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = 8'h00;
    bus.i_tx_done = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Test-plan frame: 0x20,0x12,0x34,0x01,0x01,0x06 -> 0x13, 0x35
    run_frame(8'h20, 16'h1234, 16'h0101, 1'b0, 1'b0, 1'b0);
    run_frame(8'h20, 16'h1234, 16'h0101, 1'b1, 1'b0, 1'b0);
    run_timeout();
    run_frame(8'h20, 16'h1234, 16'h0101, 1'b0, 1'b0, 1'b0);
    run_frame(8'h21, 16'hA5C3, 16'h0F0F, 1'b0, 1'b1, 1'b0);
    run_frame(8'h22, 16'hBEEF, 16'h1357, 1'b0, 1'b0, 1'b1);
    run_frame(8'h23, 16'hFFFF, 16'h00FF, 1'b0, 1'b0, 1'b0);

    // Random frames, some with bad checksums or stray rx bytes
    for (int n = 0; n < 30; n++) begin
      run_frame(8'($urandom), DATA_W'($urandom), DATA_W'($urandom),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_frame_ctrl.md
# alu_frame_ctrl

Parametrised command-frame controller between the UART byte interface and a DATA_W-bit combinational ALU. It succeeds the single-byte operand interface. It assembles multi-byte operands from received bytes and checks an XOR checksum. It then drives the ALU, captures the result and streams it back byte-by-byte through the UART transmitter with a start/done handshake, adding inter-byte timeout and error reporting.

## Interface
- DATA_W, default 16: operand/result width; must be a multiple of 8; NB = DATA_W/8 bytes per operand.
- OP_W, default 6: ALU opcode width (≤ 8); taken from the low OP_W bits of the opcode byte.
- TIMEOUT_CYC, default 100000: maximum idle clocks between bytes inside a frame.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- i_rx_done  in  1  one-cycle strobe: i_rx_data holds a new received byte.
- i_rx_data  in  8  received byte.
- i_alu_result  in  DATA_W  combinational ALU result for current o_alu_a/b/op.
- i_tx_done  in  1  one-cycle strobe: UART finished sending the byte started by o_tx_start.
- o_alu_a  out  DATA_W  operand A register.
- o_alu_b  out  DATA_W  operand B register.
- o_alu_op  out  OP_W  opcode register.
- o_tx_data  out  8  byte to transmit; held stable from o_tx_start until i_tx_done.
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data.
- o_busy  out  1  high in every state except IDLE.
- o_err  out  1  one-cycle pulse on checksum error or timeout.

## Operation
- Frame, in order: opcode byte, A (NB bytes, MSB first), B (NB bytes, MSB first), checksum byte = XOR of all preceding frame bytes.
- States: IDLE, RX_A, RX_B, RX_CHK, EXEC, TX_SEND, TX_WAIT.
- IDLE: on i_rx_done, store opcode and seed running XOR with the byte, then go to RX_A with byte counter = 0.
- RX_A / RX_B: on each i_rx_done, shift the byte into the operand LSB end (operand <= {operand[DATA_W-9:0], byte}) and XOR it into the checksum. After the NB-th byte, advance to RX_B or RX_CHK respectively.
- RX_CHK: on i_rx_done, compare the byte with the running XOR.
  - Match: go to EXEC.
  - Mismatch: pulse o_err, go to IDLE; operand/opcode registers retain the received values.
- EXEC: capture i_alu_result into the result shift register, set the tx byte counter = 0, go to TX_SEND.
- TX_SEND: drive o_tx_data = result[DATA_W-1:DATA_W-8], pulse o_tx_start, go to TX_WAIT.
- TX_WAIT: on i_tx_done, shift the result left 8 and increment the counter. If NB bytes have been sent, go to IDLE; otherwise go to TX_SEND.
- Timeout: in RX_A/RX_B/RX_CHK a counter increments each clock without i_rx_done and clears on i_rx_done. When it reaches TIMEOUT_CYC, pulse o_err, discard the frame and go to IDLE. No timeout applies in TX states.
- i_rx_done in EXEC/TX_SEND/TX_WAIT is ignored; the byte is dropped, with no error.
- i_tx_done outside TX_WAIT is ignored.
- Reset (reset=0 at a clock edge), in any state including mid-frame or mid-TX:
  - State = IDLE.
  - o_alu_a = 0, o_alu_b = 0, o_alu_op = 0, o_tx_data = 0.
  - o_tx_start = 0, o_busy = 0, o_err = 0.
  - Counters and checksum = 0.
  - A byte already handed to the UART is not recalled.

## Timing
- All outputs are registered.
- Checksum byte strobe at cycle t: EXEC during t+1, TX_SEND during t+2, o_tx_start high during cycle t+3.
- i_tx_done at cycle u: next o_tx_start high at u+2; after the last byte, o_busy low at u+1.
- o_alu_* are stable from the last B byte until the next frame's opcode; the ALU has ≥1 full cycle (RX_CHK to EXEC) to settle.
- o_err is high exactly one cycle:
  - Checksum error: cycle after the bad checksum strobe.
  - Timeout: cycle after the counter reaches TIMEOUT_CYC.
- Back-to-back: a new opcode byte is accepted from the first IDLE cycle after the final i_tx_done.

## Test plan
- DATA_W=16, frame 0x20,0x12,0x34,0x01,0x01,0x06 with ALU=ADD -> o_alu_a=0x1234, o_alu_b=0x0101; tx bytes 0x13 then 0x35; one o_tx_start per byte; o_busy low after second i_tx_done.
- Same frame with checksum 0x07 -> o_err one-cycle pulse, no o_tx_start, state IDLE, o_busy=0.
- TIMEOUT_CYC=50; send 0x20,0x12 then silence -> o_err after 50 idle cycles; the next valid frame is processed correctly.
- Extra i_rx_done (0xFF) during TX_WAIT -> ignored; result bytes unchanged, no o_err.
- reset=0 for one cycle between the two tx bytes -> all outputs 0, second o_tx_start never issued, a following frame works.
- DATA_W=8 and DATA_W=32 builds: 4-byte and 10-byte frames respectively -> correct operands and NB result bytes MSB first.
